// File: rtl/scroll_if.sv
// Control/status bundle between the scroll sequencer and its user.
// Latency: pure wiring, no storage.
// Backpressure: none; level and pulse signals only.
// Ports: enable/dir/speed/pause/restart/msg_len are driven by the master (user side);
//        offset/step/wrap/blank/state are driven by the slave (scroll_controller).
interface scroll_if #(
    parameter int MSG_LEN_MAX = 16
);
    localparam int OW = $clog2(MSG_LEN_MAX);

    logic          enable;
    logic          dir;
    logic          speed;
    logic          pause;
    logic          restart;
    logic [OW:0]   msg_len;
    logic [OW-1:0] offset;
    logic          step;
    logic          wrap;
    logic          blank;
    logic [1:0]    state;

    modport master (
        output enable, dir, speed, pause, restart, msg_len,
        input  offset, step, wrap, blank, state
    );

    modport slave (
        input  enable, dir, speed, pause, restart, msg_len,
        output offset, step, wrap, blank, state
    );
endinterface

// File: rtl/scroll_controller.sv
// Message scroller sequencer: prescaled step strobe, window offset, direction, pause and wrap dwell.
// Latency: all outputs registered; step/offset/wrap update on the same edge as the internal tick.
// Backpressure: none; pause freezes the prescaler and offset, enable=0 forces IDLE.
// Ports: clk, rst_n (async active-low) plain; bus (scroll_if.slave) carries
//        enable/dir/speed/pause/restart/msg_len in and offset/step/wrap/blank/state out.
module scroll_controller #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int SLOW_HZ     = 1,
    parameter int FAST_HZ     = 10,
    parameter int MSG_LEN_MAX = 16,
    parameter int HOLD_STEPS  = 3
) (
    input  logic     clk,
    input  logic     rst_n,
    scroll_if.slave  bus
);
    localparam int OW       = $clog2(MSG_LEN_MAX);
    localparam int DIV_SLOW = CLK_HZ / SLOW_HZ;
    localparam int DIV_FAST = CLK_HZ / FAST_HZ;
    localparam int DIV_MAX  = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
    localparam int CW       = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
    localparam int HW       = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

    localparam logic [CW-1:0] SLOW_LAST = CW'(DIV_SLOW - 1);
    localparam logic [CW-1:0] FAST_LAST = CW'(DIV_FAST - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_STEPS > 0) ? HOLD_STEPS - 1 : 0);
    localparam logic [OW:0]   LEN_MAX   = (OW + 1)'(MSG_LEN_MAX);
    localparam logic [OW:0]   LEN_TWO   = (OW + 1)'(2);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_SCROLL = 2'b01,
        S_HOLD   = 2'b10,
        S_PAUSED = 2'b11
    } state_t;

    state_t        state_r;
    logic [OW-1:0] offset_r;
    logic          step_r;
    logic          wrap_r;
    logic          blank_r;
    logic [CW-1:0] cnt;
    logic [HW-1:0] hold_cnt;
    logic [OW:0]   len_r;
    logic          speed_q;
    logic          resume_hold;

    // Prescaler compare. A speed change is seen one cycle late through speed_q
    // and restarts the period instead of producing a tick.
    logic          speed_chg;
    logic [CW-1:0] cnt_last;
    logic          at_last;
    assign speed_chg = (bus.speed != speed_q);
    assign cnt_last  = speed_q ? FAST_LAST : SLOW_LAST;
    // >= rather than == so a count left over from a speed change that happened
    // while frozen still terminates on the next running cycle.
    assign at_last   = (cnt >= cnt_last);

    // Length clamp and next-offset candidates for both directions.
    logic [OW:0]   len_in;
    logic [OW:0]   len_m1;
    logic          movable;
    logic          fwd_wrap;
    logic          rev_wrap;
    logic [OW-1:0] offset_fwd;
    logic [OW-1:0] offset_rev;
    assign len_in     = (bus.msg_len > LEN_MAX) ? LEN_MAX : bus.msg_len;
    assign len_m1     = len_r - 1'b1;
    assign movable    = (len_r >= LEN_TWO);
    assign fwd_wrap   = ({1'b0, offset_r} == len_m1);
    assign rev_wrap   = (offset_r == '0);
    assign offset_fwd = fwd_wrap ? '0 : offset_r + 1'b1;
    assign offset_rev = rev_wrap ? len_m1[OW-1:0] : offset_r - 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            offset_r    <= '0;
            step_r      <= 1'b0;
            wrap_r      <= 1'b0;
            blank_r     <= 1'b1;
            cnt         <= '0;
            hold_cnt    <= '0;
            len_r       <= '0;
            speed_q     <= 1'b0;
            resume_hold <= 1'b0;
        end else begin
            // Strobes are single-cycle by construction.
            step_r  <= 1'b0;
            wrap_r  <= 1'b0;
            speed_q <= bus.speed;

            if (!bus.enable) begin
                state_r  <= S_IDLE;
                offset_r <= '0;
                blank_r  <= 1'b1;
                cnt      <= '0;
                hold_cnt <= '0;
            end else begin
                case (state_r)
                    S_IDLE: begin
                        state_r  <= S_SCROLL;
                        offset_r <= '0;
                        blank_r  <= 1'b0;
                        cnt      <= '0;
                        hold_cnt <= '0;
                        len_r    <= len_in;
                    end

                    default: begin
                        blank_r <= 1'b0;
                        if (bus.restart) begin
                            state_r  <= S_SCROLL;
                            offset_r <= '0;
                            cnt      <= '0;
                            hold_cnt <= '0;
                            len_r    <= len_in;
                        end else if (state_r == S_PAUSED) begin
                            // Counters stay frozen on the resume cycle too.
                            if (!bus.pause) begin
                                state_r <= resume_hold ? S_HOLD : S_SCROLL;
                            end
                        end else if (bus.pause) begin
                            state_r     <= S_PAUSED;
                            resume_hold <= (state_r == S_HOLD);
                        end else if (speed_chg) begin
                            cnt <= '0;
                        end else if (at_last) begin
                            cnt <= '0;
                            if (state_r == S_HOLD) begin
                                // The final dwell tick only releases HOLD; no step.
                                if (hold_cnt == HOLD_LAST) begin
                                    state_r  <= S_SCROLL;
                                    hold_cnt <= '0;
                                end else begin
                                    hold_cnt <= hold_cnt + 1'b1;
                                end
                            end else if (movable) begin
                                step_r   <= 1'b1;
                                offset_r <= bus.dir ? offset_rev : offset_fwd;
                                if (bus.dir ? rev_wrap : fwd_wrap) begin
                                    wrap_r <= 1'b1;
                                    if (HOLD_STEPS != 0) begin
                                        state_r  <= S_HOLD;
                                        hold_cnt <= '0;
                                    end
                                end
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.offset = offset_r;
    assign bus.step   = step_r;
    assign bus.wrap   = wrap_r;
    assign bus.blank  = blank_r;
    assign bus.state  = state_r;
endmodule

// File: tb/tb_scroll_controller.sv
// Self-checking bench for scroll_controller with a behavioural reference model.
// Latency: model outputs are compared at each falling edge after the rising edge that produced them.
// Backpressure: not applicable; inputs are driven at falling edges.
module tb_scroll_controller;
    localparam int CLK_HZ      = 20;
    localparam int SLOW_HZ     = 1;
    localparam int FAST_HZ     = 4;
    localparam int MSG_LEN_MAX = 16;
    localparam int HOLD_STEPS  = 2;
    localparam int P_SLOW      = CLK_HZ / SLOW_HZ;
    localparam int P_FAST      = CLK_HZ / FAST_HZ;
    localparam logic [8:0] RESET_VEC = 9'h004;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    scroll_if #(.MSG_LEN_MAX(MSG_LEN_MAX)) bus ();

    scroll_controller #(
        .CLK_HZ(CLK_HZ), .SLOW_HZ(SLOW_HZ), .FAST_HZ(FAST_HZ),
        .MSG_LEN_MAX(MSG_LEN_MAX), .HOLD_STEPS(HOLD_STEPS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [8:0] dut_vec;
    assign dut_vec = {bus.offset, bus.step, bus.wrap, bus.blank, bus.state};

    // Reference model: time since last tick, remaining dwell ticks, and the
    // message window position as modular arithmetic over the latched length.
    typedef struct packed {
        logic active;
        logic paused;
        logic step;
        logic wrap;
        logic prev_speed;
        int   hold_left;
        int   elapsed;
        int   len;
        int   off;
    } mdl_t;

    mdl_t m;
    logic [8:0] mdl_vec;

    function automatic mdl_t model_next(input mdl_t c, input logic en, input logic d,
                                        input logic sp, input logic pz, input logic rs,
                                        input int len_in);
        mdl_t n;
        int   period;
        int   nxt;
        n = c;
        n.step = 1'b0;
        n.wrap = 1'b0;
        period = c.prev_speed ? P_FAST : P_SLOW;
        if (!en) begin
            n.active = 1'b0; n.paused = 1'b0; n.off = 0; n.elapsed = 0; n.hold_left = 0;
        end else if (!c.active || rs) begin
            n.active = 1'b1; n.paused = 1'b0; n.off = 0; n.elapsed = 0; n.hold_left = 0;
            n.len = (len_in > MSG_LEN_MAX) ? MSG_LEN_MAX : len_in;
        end else if (c.paused) begin
            n.paused = pz;
        end else if (pz) begin
            n.paused = 1'b1;
        end else if (sp != c.prev_speed) begin
            n.elapsed = 0;
        end else if (c.elapsed + 1 < period) begin
            n.elapsed = c.elapsed + 1;
        end else begin
            n.elapsed = 0;
            if (c.hold_left > 0) begin
                n.hold_left = c.hold_left - 1;
            end else if (c.len >= 2) begin
                nxt = (c.off + (d ? c.len - 1 : 1)) % c.len;
                n.off = nxt;
                n.step = 1'b1;
                if (d ? (nxt > c.off) : (nxt < c.off)) begin
                    n.wrap = 1'b1;
                    n.hold_left = HOLD_STEPS;
                end
            end
        end
        n.prev_speed = sp;
        return n;
    endfunction

    function automatic logic [8:0] mdl_vec_f(input mdl_t c);
        logic [1:0] st;
        if (!c.active)          st = 2'd0;
        else if (c.paused)      st = 2'd3;
        else if (c.hold_left > 0) st = 2'd2;
        else                    st = 2'd1;
        return {4'(c.off), c.step, c.wrap, ~c.active, st};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else m <= model_next(m, bus.enable, bus.dir, bus.speed, bus.pause, bus.restart,
                             int'(bus.msg_len));
    end

    always_comb mdl_vec = mdl_vec_f(m);

    // Leaves the DUT in SCROLL, observed at the falling edge right after entry.
    task automatic start_run(input int len, input logic d, input logic s);
        bus.enable  = 1'b0;
        bus.pause   = 1'b0;
        bus.restart = 1'b0;
        @(negedge clk);
        bus.enable  = 1'b1;
        bus.msg_len = 5'(len);
        bus.dir     = d;
        bus.speed   = s;
        @(negedge clk);
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if (dut_vec !== RESET_VEC) begin
            errors++; $display("FAIL reset_in got=%h want=%h", dut_vec, RESET_VEC);
        end
        checks++;
        if (mdl_vec !== dut_vec) begin
            errors++; $display("FAIL reset_model got=%h want=%h", dut_vec, mdl_vec);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (dut_vec !== RESET_VEC) begin
            errors++; $display("FAIL reset_idle got=%h want=%h", dut_vec, RESET_VEC);
        end
    endtask

    task automatic test_scroll_left;
        int eoff; logic estep; logic ewrap;
        start_run(11, 1'b0, 1'b0);
        checks++;
        if (bus.state !== 2'b01 || bus.blank !== 1'b0 || bus.offset !== 4'd0) begin
            errors++;
            $display("FAIL t1_entry state=%0d blank=%0b offset=%0d want 1/0/0",
                     bus.state, bus.blank, bus.offset);
        end
        for (int i = 1; i <= 280; i++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++; $display("FAIL t1_model cyc=%0d got=%h want=%h", i, dut_vec, mdl_vec);
            end
            estep = ((i % 20 == 0) && (i <= 220)) || (i == 280);
            ewrap = (i == 220);
            eoff  = (i >= 280) ? 1 : (i >= 220) ? 0 : i / 20;
            checks++;
            if (bus.step !== estep || bus.wrap !== ewrap || bus.offset !== 4'(eoff)) begin
                errors++;
                $display("FAIL t1_seq cyc=%0d got step=%0b wrap=%0b off=%0d want %0b/%0b/%0d",
                         i, bus.step, bus.wrap, bus.offset, estep, ewrap, eoff);
            end
            if (i == 230 || i == 270) begin
                checks++;
                if (bus.state !== ((i == 230) ? 2'b10 : 2'b01)) begin
                    errors++; $display("FAIL t1_hold cyc=%0d state=%0d", i, bus.state);
                end
            end
        end
    endtask

    task automatic test_dir_hold;
        int eoff; logic estep; logic ewrap;
        start_run(11, 1'b1, 1'b0);
        for (int i = 1; i <= 140; i++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++; $display("FAIL t2_model cyc=%0d got=%h want=%h", i, dut_vec, mdl_vec);
            end
            estep = (i == 20 || i == 80 || i == 140);
            ewrap = (i == 20 || i == 80);
            eoff  = (i < 20) ? 0 : (i < 80) ? 10 : (i < 140) ? 0 : 1;
            checks++;
            if (bus.step !== estep || bus.wrap !== ewrap || bus.offset !== 4'(eoff)) begin
                errors++;
                $display("FAIL t2_seq cyc=%0d got step=%0b wrap=%0b off=%0d want %0b/%0b/%0d",
                         i, bus.step, bus.wrap, bus.offset, estep, ewrap, eoff);
            end
            if (i == 30) begin
                checks++;
                if (bus.state !== 2'b10) begin
                    errors++; $display("FAIL t2_hold state=%0d want 2", bus.state);
                end
                bus.dir = 1'b0;
            end
        end
    endtask

    task automatic test_speed_change;
        int eoff; logic estep;
        start_run(11, 1'b0, 1'b0);
        for (int i = 1; i <= 28; i++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++; $display("FAIL t3_model cyc=%0d got=%h want=%h", i, dut_vec, mdl_vec);
            end
            estep = (i == 18 || i == 23 || i == 28);
            eoff  = (i < 18) ? 0 : (i < 23) ? 1 : (i < 28) ? 2 : 3;
            checks++;
            if (bus.step !== estep || bus.offset !== 4'(eoff)) begin
                errors++;
                $display("FAIL t3_seq cyc=%0d got step=%0b off=%0d want %0b/%0d",
                         i, bus.step, bus.offset, estep, eoff);
            end
            if (i == 12) bus.speed = 1'b1;
        end
        bus.speed = 1'b0;
    endtask

    task automatic test_pause;
        int eoff; logic estep;
        start_run(11, 1'b0, 1'b0);
        for (int i = 1; i <= 138; i++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++; $display("FAIL t4_model cyc=%0d got=%h want=%h", i, dut_vec, mdl_vec);
            end
            estep = (i == 20 || i == 40 || i == 60 || i == 80 || i == 138);
            eoff  = (i >= 138) ? 5 : (i >= 80) ? 4 : i / 20;
            checks++;
            if (bus.step !== estep || bus.offset !== 4'(eoff)) begin
                errors++;
                $display("FAIL t4_seq cyc=%0d got step=%0b off=%0d want %0b/%0d",
                         i, bus.step, bus.offset, estep, eoff);
            end
            if (i >= 88 && i <= 125) begin
                checks++;
                if (bus.state !== ((i == 125) ? 2'b01 : 2'b11)) begin
                    errors++; $display("FAIL t4_state cyc=%0d state=%0d", i, bus.state);
                end
            end
            if (i == 87)  bus.pause = 1'b1;
            if (i == 124) bus.pause = 1'b0;
        end
    endtask

    task automatic test_restart;
        int eoff; logic estep; logic ewrap;
        start_run(11, 1'b0, 1'b0);
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++; $display("FAIL t5_model cyc=%0d got=%h want=%h", i, dut_vec, mdl_vec);
            end
            estep = (i % 20 == 0) && (i != 140);
            ewrap = (i == 200);
            eoff  = (i < 140) ? i / 20 : (i < 160) ? 0 : (i < 180) ? 1 : (i < 200) ? 2 : 0;
            checks++;
            if (bus.step !== estep || bus.wrap !== ewrap || bus.offset !== 4'(eoff)) begin
                errors++;
                $display("FAIL t5_seq cyc=%0d got step=%0b wrap=%0b off=%0d want %0b/%0b/%0d",
                         i, bus.step, bus.wrap, bus.offset, estep, ewrap, eoff);
            end
            if (i == 139) begin
                bus.restart = 1'b1;
                bus.msg_len = 5'd3;
            end
            if (i == 140) bus.restart = 1'b0;
        end
    endtask

    task automatic test_random;
        start_run(int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++; $display("FAIL rnd_model cyc=%0d got=%h want=%h", i, dut_vec, mdl_vec);
            end
            bus.restart = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 49) == 0) bus.pause = ~bus.pause;
            if ($urandom_range(0, 49) == 0) bus.dir = ~bus.dir;
            if ($urandom_range(0, 99) == 0) bus.speed = ~bus.speed;
            if ($urandom_range(0, 9) == 0) bus.msg_len = 5'($urandom_range(0, 20));
            if (bus.enable) bus.enable = ($urandom_range(0, 199) != 0);
            else            bus.enable = ($urandom_range(0, 3) == 0);
        end
        bus.pause   = 1'b0;
        bus.restart = 1'b0;
    endtask

    task automatic test_degenerate_reset;
        start_run(1, 1'b0, 1'b0);
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== 9'h001 || dut_vec !== mdl_vec) begin
                errors++;
                $display("FAIL t6_len1 cyc=%0d got=%h want=001 model=%h", i, dut_vec, mdl_vec);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (dut_vec !== RESET_VEC || mdl_vec !== RESET_VEC) begin
            errors++;
            $display("FAIL t6_async_rst got=%h want=%h model=%h", dut_vec, RESET_VEC, mdl_vec);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.state !== 2'b01 || bus.blank !== 1'b0) begin
            errors++; $display("FAIL t6_rerun state=%0d blank=%0b want 1/0", bus.state, bus.blank);
        end
        bus.enable = 1'b0;
        @(negedge clk);
        checks++;
        if (dut_vec !== RESET_VEC) begin
            errors++; $display("FAIL t6_disable got=%h want=%h", dut_vec, RESET_VEC);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        bus.enable  = 1'b0;
        bus.dir     = 1'b0;
        bus.speed   = 1'b0;
        bus.pause   = 1'b0;
        bus.restart = 1'b0;
        bus.msg_len = '0;
        test_reset;
        test_scroll_left;
        test_dir_hold;
        test_speed_change;
        test_pause;
        test_restart;
        test_random;
        test_degenerate_reset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/scroll_controller.md
Name: scroll_controller

Overview:
Sequencer for the message scroller. It runs from the 50 MHz system clock and replaces the derived scroll clock with a single-cycle step strobe. It owns scroll position (window offset), direction, speed, pause and end-of-message dwell. The scroller datapath consumes `offset` and `step` and selects the NUM_DISPLAYS characters starting at `offset`.

Parameters:
CLK_HZ, 50_000_000, input clock frequency
SLOW_HZ, 1, step rate when speed=0
FAST_HZ, 10, step rate when speed=1
MSG_LEN_MAX, 16, largest message length supported; sets offset width OW = $clog2(MSG_LEN_MAX)
HOLD_STEPS, 3, step periods to dwell after each wrap

Ports:
clk  input  1  system clock (50 MHz)
rst_n  input  1  asynchronous active-low reset
enable  input  1  1 = run; 0 = idle, display blanked
dir  input  1  0 = left-to-right (offset increments), 1 = right-to-left (offset decrements)
speed  input  1  0 = SLOW_HZ, 1 = FAST_HZ
pause  input  1  1 = freeze prescaler and offset
restart  input  1  single-cycle pulse: return to offset 0 and relatch msg_len
msg_len  input  OW+1  length of current message in characters
offset  output  OW  index of first character shown
step  output  1  one-cycle pulse coincident with each offset change
wrap  output  1  one-cycle pulse when offset wraps
blank  output  1  1 = datapath drives all displays blank
state  output  2  00 IDLE, 01 SCROLL, 10 HOLD, 11 PAUSED

Behaviour:
- Reset is asynchronous and active-low. Clock is clk, reset is rst_n. During and after reset: offset=0, step=0, wrap=0, blank=1, state=IDLE, prescaler=0, latched length L=0.
- Prescaler:
  - DIV = CLK_HZ/SLOW_HZ or CLK_HZ/FAST_HZ, selected by speed.
  - Counts 0..DIV-1. The internal tick fires on the edge where count==DIV-1, and count returns to 0.
  - Any change of speed (registered compare) clears count to 0 with no tick that cycle.
  - The prescaler is held at 0 in IDLE and frozen in PAUSED.
- Length latch:
  - L = min(msg_len, MSG_LEN_MAX).
  - Latched on the IDLE->SCROLL transition and on restart. msg_len changes at other times are ignored.
- FSM transitions:
  - IDLE: blank=1, offset=0. enable=1 -> SCROLL next cycle, prescaler=0, L latched.
  - SCROLL: blank=0. On tick:
    - dir=0: offset <= (offset==L-1) ? 0 : offset+1.
    - dir=1: offset <= (offset==0) ? L-1 : offset-1.
    - step=1 in the same cycle the new offset is visible (registered outputs, no extra latency).
    - If the update wrapped, wrap=1 that cycle and the FSM goes to HOLD with hold count=0.
  - HOLD: offset frozen, blank=0. Each tick increments the hold count. On the HOLD_STEPS-th tick -> SCROLL, with no step on that tick. HOLD_STEPS=0 means HOLD is skipped.
  - PAUSED: entered from SCROLL or HOLD when pause=1. Offset, prescaler and hold count are frozen; blank=0. pause=0 returns to the saved state (SCROLL or HOLD) next cycle and resumes the count.
  - enable=0 in any state -> IDLE next cycle, offset=0, blank=1. This has highest priority.
- Degenerate length: L<2 means offset stays 0, step and wrap never assert, and the FSM stays in SCROLL (ticks ignored).
- dir is sampled only at a tick. A direction change mid-message continues from the current offset with no glitch step.
- restart:
  - Ignored in IDLE.
  - Otherwise: offset=0, prescaler=0, hold count=0, L relatched, state=SCROLL, step=0.
  - Priority: restart beats tick and pause in the same cycle.
  - Priority order: rst_n > enable=0 > restart > pause > tick.
- step and wrap are never asserted for more than one consecutive cycle. wrap implies step.

Test Plan:
Bench parameters: CLK_HZ=20, SLOW_HZ=1 (DIV=20), FAST_HZ=4 (DIV=5), MSG_LEN_MAX=16, HOLD_STEPS=2.
1. Reset, enable=1, msg_len=11, dir=0, speed=0 -> SCROLL 1 cycle after enable. step every 20 cycles. offset 1,2,…,10, then 0 with wrap=1. State HOLD for the next 2 ticks with no step, then offset 1 on the following tick.
2. dir=1, msg_len=11 from IDLE -> first tick gives offset=10 with wrap=1 and HOLD. Toggle dir to 0 mid-HOLD -> after HOLD, offset goes 0, 1, …
3. speed toggled 0->1 when prescaler=12 -> no tick that cycle. Next step exactly 5 cycles later, then every 5 cycles.
4. pause=1 for 37 cycles at offset=4 with 7 cycles elapsed -> offset stays 4 and state=PAUSED. After pause=0, next step lands 13 cycles later (plus 1 resume cycle), giving offset 5.
5. restart pulse on the same cycle as a tick at offset=6, with msg_len changed to 3 -> offset=0, no step, L=3. Subsequent offsets 1, 2, 0 (wrap).
6. msg_len=1 -> no step or wrap over 200 cycles, offset=0, blank=0. Assert rst_n=0 asynchronously mid-cycle -> all outputs return to reset values immediately. enable=0 -> IDLE with blank=1 next cycle.
